// File: rtl/bt_cmd_parser.sv
// HC-05 ASCII command frame decoder: letter, 0-3 digits, CR/LF terminator.
// Define BT_CMD_ACK_EN to add the 'K'/'N' acknowledge byte outputs.
module bt_cmd_parser #(
   parameter int CLK_FREQ       = 50000000,
   parameter int TIMEOUT_CYCLES = 5000000,
   parameter int MAX_AZ         = 180,
   parameter int MAX_EL         = 90,
   parameter int INIT_AZ        = 90,
   parameter int INIT_EL        = 45
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       manual_mode,
   output logic [7:0] az_angle,
   output logic [7:0] el_angle,
   output logic       cmd_valid,
   output logic [7:0] cmd_code,
`ifdef BT_CMD_ACK_EN
   output logic       cmd_error,
   output logic       ack_valid,
   output logic [7:0] ack_byte
`else
   output logic       cmd_error
`endif
);

   // CLK_FREQ only documents TIMEOUT_CYCLES; a nonsensical value collapses the timer.
   localparam int CW = (CLK_FREQ > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DIGITS  = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [9:0]      acc_q, acc_d;
   logic [1:0]      ndig_q, ndig_d;
   logic [7:0]      let_q, let_d;
   logic [CW-1:0]   tmo_q, tmo_d;
   logic            man_q, man_d;
   logic [7:0]      az_q, az_d;
   logic [7:0]      el_q, el_d;
   logic [7:0]      code_q, code_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;

   logic is_term, is_digit, is_letter, frame_ok;

   assign is_term   = (rx_byte == 8'h0A) || (rx_byte == 8'h0D);
   assign is_digit  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
   assign is_letter = (rx_byte == 8'h41) || (rx_byte == 8'h45) ||
                      (rx_byte == 8'h4D) || (rx_byte == 8'h55);

   always_comb begin
      frame_ok = 1'b0;
      unique case (let_q)
         8'h41:   frame_ok = (ndig_q != 2'd0) && (acc_q <= 10'(MAX_AZ));
         8'h45:   frame_ok = (ndig_q != 2'd0) && (acc_q <= 10'(MAX_EL));
         8'h4D:   frame_ok = (ndig_q == 2'd0);
         8'h55:   frame_ok = (ndig_q == 2'd0);
         default: frame_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ndig_d  = ndig_q;
      let_d   = let_q;
      tmo_d   = tmo_q;
      man_d   = man_q;
      az_d    = az_q;
      el_d    = el_q;
      code_d  = code_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            tmo_d = '0;
            if (rx_valid && !is_term) begin
               if (is_letter) begin
                  let_d   = rx_byte;
                  acc_d   = '0;
                  ndig_d  = '0;
                  state_d = DIGITS;
               end else begin
                  state_d = DISCARD;
               end
            end
         end
         DIGITS: begin
            if (rx_valid) begin
               tmo_d = '0;
               if (is_digit && ndig_q != 2'd3) begin
                  acc_d  = acc_q * 10'd10 + {6'd0, rx_byte[3:0]};
                  ndig_d = ndig_q + 2'd1;
               end else if (is_term) begin
                  state_d = IDLE;
                  if (frame_ok) begin
                     valid_d = 1'b1;
                     code_d  = let_q;
                     unique case (let_q)
                        8'h41:   az_d  = acc_q[7:0];
                        8'h45:   el_d  = acc_q[7:0];
                        8'h4D:   man_d = 1'b1;
                        default: man_d = 1'b0;
                     endcase
                  end else begin
                     err_d = 1'b1;
                  end
               end else begin
                  state_d = DISCARD;
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_d   = '0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + CW'(1);
            end
         end
         DISCARD: begin
            if (rx_valid) begin
               tmo_d = '0;
               if (is_term) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end else if (tmo_q == TMO_LAST) begin
               tmo_d   = '0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tmo_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ndig_q  <= '0;
         let_q   <= '0;
         tmo_q   <= '0;
         man_q   <= 1'b0;
         az_q    <= 8'(INIT_AZ);
         el_q    <= 8'(INIT_EL);
         code_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ndig_q  <= ndig_d;
         let_q   <= let_d;
         tmo_q   <= tmo_d;
         man_q   <= man_d;
         az_q    <= az_d;
         el_q    <= el_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign manual_mode = man_q;
   assign az_angle    = az_q;
   assign el_angle    = el_q;
   assign cmd_valid   = valid_q;
   assign cmd_code    = code_q;
   assign cmd_error   = err_q;

`ifdef BT_CMD_ACK_EN
   logic       ackv_q;
   logic [7:0] ackb_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ackv_q <= 1'b0;
         ackb_q <= '0;
      end else begin
         ackv_q <= valid_d | err_d;
         if (valid_d) begin
            ackb_q <= 8'h4B;
         end else if (err_d) begin
            ackb_q <= 8'h4E;
         end
      end
   end

   assign ack_valid = ackv_q;
   assign ack_byte  = ackb_q;
`endif

endmodule
